// File: rtl/eq_menu_pkg.sv
// Shared state/menu encodings for the equalizer menu controller.
// Optional auto-repeat is enabled with the EQ_MENU_AUTOREPEAT_EN macro.
package eq_menu_pkg;

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_MENU       = 3'd2,
    ST_BAND_SEL   = 3'd3,
    ST_SET_GAIN   = 3'd4,
    ST_SET_OFFSET = 3'd5,
    ST_RESET_DSP  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    MENU_EQ     = 2'd0,
    MENU_OFFSET = 2'd1,
    MENU_RESET  = 2'd2
  } menu_e;

  localparam int STATE_W   = 3;
  localparam int MENU_W    = 2;
  localparam int N_BUTTONS = 4;

endpackage

// File: rtl/eq_btn_repeat.sv
// Rising-edge press detector for one debounced button, with an optional
// hold-to-repeat counter when EQ_MENU_AUTOREPEAT_EN is defined.
module eq_btn_repeat
  import eq_menu_pkg::*;
#(
  parameter int REPEAT_DELAY = 400000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  input  logic i_hold_ok,
  output logic o_press
);

  logic level_q;
  logic level_d;

  assign level_d = i_level;

`ifdef EQ_MENU_AUTOREPEAT_EN
  localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rep_fire;

  // Counter runs only while the button stays held after its edge; after the
  // first repeat it reloads so later repeats come every REPEAT_RATE cycles.
  always_comb begin
    cnt_d    = '0;
    rep_fire = 1'b0;
    if (i_level && level_q && i_hold_ok) begin
      if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
        rep_fire = 1'b1;
        cnt_d    = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_press = (i_level & ~level_q) | rep_fire;
`else
  logic unused_cfg;
  assign unused_cfg = i_hold_ok ^ (REPEAT_DELAY > REPEAT_RATE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign o_press = i_level & ~level_q;
`endif

endmodule

// File: rtl/eq_menu_ctrl.sv
// Button-driven menu FSM for the EQ/visualizer: band gain edit, offset, DSP reset.
// Define EQ_MENU_AUTOREPEAT_EN to enable hold-to-repeat on up/down.
module eq_menu_ctrl
  import eq_menu_pkg::*;
#(
  parameter int N_BAND       = 7,
  parameter int GAIN_W       = 16,
  parameter int GAIN_MAX     = 12,
  parameter int GAIN_MIN     = -12,
  parameter int OFFSET_MAX   = 3,
  parameter int REPEAT_DELAY = 400000,
  parameter int REPEAT_RATE  = 100000,
  localparam int BAND_W      = $clog2(N_BAND),
  localparam int OFF_W       = $clog2(OFFSET_MAX + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_select,
  input  logic                     i_back,
  input  logic                     i_up,
  input  logic                     i_down,
  output logic                     o_i2c_start,
  input  logic                     i_i2c_done,
  output logic [STATE_W-1:0]       o_state,
  output logic [MENU_W-1:0]        o_menu_sel,
  output logic [BAND_W-1:0]        o_band,
  output logic [GAIN_W-1:0]        o_gain_cur,
  output logic [N_BAND*GAIN_W-1:0] o_gains,
  output logic [OFF_W-1:0]         o_offset,
  output logic                     o_dsp_rst,
  output logic                     o_upd_valid,
  output logic [BAND_W-1:0]        o_upd_band,
  output logic [GAIN_W-1:0]        o_upd_gain,
  input  logic                     i_upd_ready
);

  localparam logic signed [GAIN_W-1:0] G_MAX = GAIN_W'(GAIN_MAX);
  localparam logic signed [GAIN_W-1:0] G_MIN = GAIN_W'(GAIN_MIN);

  state_e                    state_q, state_d;
  menu_e                     menu_sel_q, menu_sel_d;
  logic [BAND_W-1:0]         band_q, band_d;
  logic signed [GAIN_W-1:0]  gain_work_q, gain_work_d;
  logic signed [GAIN_W-1:0]  gains_q [N_BAND];
  logic signed [GAIN_W-1:0]  gains_d [N_BAND];
  logic [GAIN_W-1:0]         gain_cur_q, gain_cur_d;
  logic [OFF_W-1:0]          offset_q, offset_d;
  logic                      dsp_rst_q, dsp_rst_d;
  logic                      upd_valid_q, upd_valid_d;
  logic [BAND_W-1:0]         upd_band_q, upd_band_d;
  logic [GAIN_W-1:0]         upd_gain_q, upd_gain_d;
  logic                      i2c_start_q, i2c_start_d;

  logic p_select, p_back, p_up, p_down;
  logic hold_up, hold_down;
  logic back_ev, sel_ev, up_ev, dn_ev;

`ifdef EQ_MENU_AUTOREPEAT_EN
  state_e last_state_q, last_state_d;
  logic   rep_state;

  // Repeat only while a single up/down is held in an editing state that has
  // not just changed; any other button or a transition restarts the counter.
  assign last_state_d = state_q;
  assign rep_state    = (state_q == ST_BAND_SEL) || (state_q == ST_SET_GAIN) ||
                        (state_q == ST_SET_OFFSET);
  assign hold_up      = rep_state && (state_q == last_state_q) &&
                        i_up && !i_down && !i_select && !i_back;
  assign hold_down    = rep_state && (state_q == last_state_q) &&
                        i_down && !i_up && !i_select && !i_back;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) last_state_q <= ST_INIT;
    else       last_state_q <= last_state_d;
  end
`else
  assign hold_up   = 1'b0;
  assign hold_down = 1'b0;
`endif

  eq_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_btn_select (
    .i_clk(i_clk), .i_rst(i_rst), .i_level(i_select), .i_hold_ok(1'b0), .o_press(p_select));
  eq_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_btn_back (
    .i_clk(i_clk), .i_rst(i_rst), .i_level(i_back), .i_hold_ok(1'b0), .o_press(p_back));
  eq_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_btn_up (
    .i_clk(i_clk), .i_rst(i_rst), .i_level(i_up), .i_hold_ok(hold_up), .o_press(p_up));
  eq_btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_btn_down (
    .i_clk(i_clk), .i_rst(i_rst), .i_level(i_down), .i_hold_ok(hold_down), .o_press(p_down));

  assign back_ev = p_back;
  assign sel_ev  = p_select & ~p_back;
  assign up_ev   = p_up & ~p_back & ~p_select;
  assign dn_ev   = p_down & ~p_back & ~p_select & ~p_up;

  always_comb begin
    state_d     = state_q;
    menu_sel_d  = menu_sel_q;
    band_d      = band_q;
    gain_work_d = gain_work_q;
    gains_d     = gains_q;
    offset_d    = offset_q;
    dsp_rst_d   = 1'b0;
    upd_valid_d = upd_valid_q;
    upd_band_d  = upd_band_q;
    upd_gain_d  = upd_gain_q;
    i2c_start_d = i2c_start_q;

    if (upd_valid_q && i_upd_ready) upd_valid_d = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (i_i2c_done) begin
          state_d     = ST_IDLE;
          i2c_start_d = 1'b0;
        end
      end
      ST_IDLE: begin
        if (sel_ev) begin
          state_d    = ST_MENU;
          menu_sel_d = MENU_EQ;
        end
      end
      ST_MENU: begin
        if (back_ev) begin
          state_d = ST_IDLE;
        end else if (sel_ev) begin
          case (menu_sel_q)
            MENU_EQ:     state_d = ST_BAND_SEL;
            MENU_OFFSET: state_d = ST_SET_OFFSET;
            default: begin
              // Clear on entry so o_gains/o_offset read zero during the pulse.
              state_d     = ST_RESET_DSP;
              dsp_rst_d   = 1'b1;
              offset_d    = '0;
              upd_valid_d = 1'b0;
              for (int b = 0; b < N_BAND; b++) gains_d[b] = '0;
            end
          endcase
        end else if (up_ev && menu_sel_q != MENU_RESET) begin
          menu_sel_d = menu_e'(menu_sel_q + 2'd1);
        end else if (dn_ev && menu_sel_q != MENU_EQ) begin
          menu_sel_d = menu_e'(menu_sel_q - 2'd1);
        end
      end
      ST_BAND_SEL: begin
        if (back_ev) begin
          state_d = ST_MENU;
        end else if (sel_ev) begin
          if (!upd_valid_q) begin
            state_d     = ST_SET_GAIN;
            gain_work_d = gains_q[band_q];
          end
        end else if (up_ev && band_q != BAND_W'(N_BAND - 1)) begin
          band_d = band_q + 1'b1;
        end else if (dn_ev && band_q != '0) begin
          band_d = band_q - 1'b1;
        end
      end
      ST_SET_GAIN: begin
        if (back_ev) begin
          state_d = ST_BAND_SEL;
        end else if (sel_ev) begin
          state_d         = ST_BAND_SEL;
          gains_d[band_q] = gain_work_q;
          upd_valid_d     = 1'b1;
          upd_band_d      = band_q;
          upd_gain_d      = gain_work_q;
        end else if (up_ev && gain_work_q < G_MAX) begin
          gain_work_d = gain_work_q + GAIN_W'(1);
        end else if (dn_ev && gain_work_q > G_MIN) begin
          gain_work_d = gain_work_q - GAIN_W'(1);
        end
      end
      ST_SET_OFFSET: begin
        if (back_ev || sel_ev) begin
          state_d = ST_MENU;
        end else if (up_ev && offset_q != OFF_W'(OFFSET_MAX)) begin
          offset_d = offset_q + 1'b1;
        end else if (dn_ev && offset_q != '0) begin
          offset_d = offset_q - 1'b1;
        end
      end
      ST_RESET_DSP: state_d = ST_MENU;
      default:      state_d = ST_INIT;
    endcase

    gain_cur_d = (state_d == ST_SET_GAIN) ? gain_work_d : gains_d[band_d];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_INIT;
      menu_sel_q  <= MENU_EQ;
      band_q      <= '0;
      gain_work_q <= '0;
      gains_q     <= '{default: '0};
      gain_cur_q  <= '0;
      offset_q    <= '0;
      dsp_rst_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_band_q  <= '0;
      upd_gain_q  <= '0;
      i2c_start_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      menu_sel_q  <= menu_sel_d;
      band_q      <= band_d;
      gain_work_q <= gain_work_d;
      gains_q     <= gains_d;
      gain_cur_q  <= gain_cur_d;
      offset_q    <= offset_d;
      dsp_rst_q   <= dsp_rst_d;
      upd_valid_q <= upd_valid_d;
      upd_band_q  <= upd_band_d;
      upd_gain_q  <= upd_gain_d;
      i2c_start_q <= i2c_start_d;
    end
  end

  for (genvar g = 0; g < N_BAND; g++) begin : g_pack
    assign o_gains[g*GAIN_W +: GAIN_W] = gains_q[g];
  end

  assign o_i2c_start = i2c_start_q;
  assign o_state     = state_q;
  assign o_menu_sel  = menu_sel_q;
  assign o_band      = band_q;
  assign o_gain_cur  = gain_cur_q;
  assign o_offset    = offset_q;
  assign o_dsp_rst   = dsp_rst_q;
  assign o_upd_valid = upd_valid_q;
  assign o_upd_band  = upd_band_q;
  assign o_upd_gain  = upd_gain_q;

endmodule

// File: tb/tb_eq_menu_ctrl.sv
// Directed self-checking bench for eq_menu_ctrl (7 bands, 16-bit gains).
// Autorepeat expectations follow EQ_MENU_AUTOREPEAT_EN when it is defined.
module tb_eq_menu_ctrl;

  localparam int N_BAND = 7;
  localparam int GAIN_W = 16;

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_BACK = 4'b1000;
  localparam logic [3:0] B_SEL  = 4'b0100;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0001;

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic                     i_select, i_back, i_up, i_down;
  logic                     o_i2c_start;
  logic                     i_i2c_done;
  logic [2:0]               o_state;
  logic [1:0]               o_menu_sel;
  logic [2:0]               o_band;
  logic [GAIN_W-1:0]        o_gain_cur;
  logic [N_BAND*GAIN_W-1:0] o_gains;
  logic [1:0]               o_offset;
  logic                     o_dsp_rst;
  logic                     o_upd_valid;
  logic [2:0]               o_upd_band;
  logic [GAIN_W-1:0]        o_upd_gain;
  logic                     i_upd_ready;

  int compareCount  = 0;
  int mismatchCount = 0;
  logic [N_BAND*GAIN_W-1:0] expGains;

  eq_menu_ctrl #(
    .N_BAND(N_BAND), .GAIN_W(GAIN_W), .GAIN_MAX(12), .GAIN_MIN(-12),
    .OFFSET_MAX(3), .REPEAT_DELAY(10), .REPEAT_RATE(4)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_select(i_select), .i_back(i_back), .i_up(i_up), .i_down(i_down),
    .o_i2c_start(o_i2c_start), .i_i2c_done(i_i2c_done),
    .o_state(o_state), .o_menu_sel(o_menu_sel), .o_band(o_band),
    .o_gain_cur(o_gain_cur), .o_gains(o_gains), .o_offset(o_offset),
    .o_dsp_rst(o_dsp_rst), .o_upd_valid(o_upd_valid), .o_upd_band(o_upd_band),
    .o_upd_gain(o_upd_gain), .i_upd_ready(i_upd_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One idle cycle so the previous press is seen released, then drive the
  // buttons for holdCycles edges and release; callers check right after.
  task automatic applyStimulus(input logic [3:0] btns, input int holdCycles);
    tick();
    {i_back, i_select, i_up, i_down} = btns;
    repeat (holdCycles) tick();
    {i_back, i_select, i_up, i_down} = B_NONE;
  endtask

  task automatic pressN(input logic [3:0] btns, input int n);
    for (int k = 0; k < n; k++) applyStimulus(btns, 1);
  endtask

  initial begin
    i_rst = 1'b1;
    {i_back, i_select, i_up, i_down} = B_NONE;
    i_i2c_done  = 1'b0;
    i_upd_ready = 1'b0;
    repeat (2) @(negedge i_clk);

    checkOutput("rst_state",     128'(o_state),     128'(0));
    checkOutput("rst_i2c_start", 128'(o_i2c_start), 128'(1));
    checkOutput("rst_menu_sel",  128'(o_menu_sel),  128'(0));
    checkOutput("rst_band",      128'(o_band),      128'(0));
    checkOutput("rst_gains",     128'(o_gains),     128'(0));
    checkOutput("rst_offset",    128'(o_offset),    128'(0));
    checkOutput("rst_dsp_rst",   128'(o_dsp_rst),   128'(0));
    checkOutput("rst_upd_valid", 128'(o_upd_valid), 128'(0));
    checkOutput("rst_upd_band",  128'(o_upd_band),  128'(0));
    checkOutput("rst_upd_gain",  128'(o_upd_gain),  128'(0));

    i_rst = 1'b0;
    repeat (4) tick();
    checkOutput("init_wait_state", 128'(o_state), 128'(0));
    checkOutput("init_wait_start", 128'(o_i2c_start), 128'(1));
    i_i2c_done = 1'b1;
    tick();
    i_i2c_done = 1'b0;
    checkOutput("init_done_state", 128'(o_state), 128'(1));
    checkOutput("init_done_start", 128'(o_i2c_start), 128'(0));

    applyStimulus(B_SEL, 1);
    checkOutput("idle_to_menu", 128'(o_state), 128'(2));
    checkOutput("menu_cursor0", 128'(o_menu_sel), 128'(0));
    applyStimulus(B_SEL, 1);
    checkOutput("menu_to_band", 128'(o_state), 128'(3));
    pressN(B_UP, 3);
    checkOutput("band_up3", 128'(o_band), 128'(3));
    applyStimulus(B_SEL, 1);
    checkOutput("band_to_gain", 128'(o_state), 128'(4));
    checkOutput("gain_entry", 128'(o_gain_cur), 128'(0));
    pressN(B_UP, 15);
    checkOutput("gain_sat_max", 128'(o_gain_cur), 128'(12));
    checkOutput("gains_uncommitted", 128'(o_gains), 128'(0));
    applyStimulus(B_SEL, 1);
    expGains = '0;
    expGains[3*GAIN_W +: GAIN_W] = 16'd12;
    checkOutput("commit_state",     128'(o_state),     128'(3));
    checkOutput("commit_gains",     128'(o_gains),     128'(expGains));
    checkOutput("commit_valid",     128'(o_upd_valid), 128'(1));
    checkOutput("commit_upd_band",  128'(o_upd_band),  128'(3));
    checkOutput("commit_upd_gain",  128'(o_upd_gain),  128'(12));
    checkOutput("commit_gain_cur",  128'(o_gain_cur),  128'(12));
    repeat (3) tick();
    checkOutput("valid_held", 128'(o_upd_valid), 128'(1));
    applyStimulus(B_SEL, 1);
    checkOutput("pending_blocks_sel", 128'(o_state), 128'(3));
    checkOutput("pending_band_stable", 128'(o_upd_band), 128'(3));
    i_upd_ready = 1'b1;
    tick();
    i_upd_ready = 1'b0;
    checkOutput("ready_clears_valid", 128'(o_upd_valid), 128'(0));

    applyStimulus(B_DOWN, 1);
    checkOutput("band_down", 128'(o_band), 128'(2));
    applyStimulus(B_SEL, 1);
    pressN(B_DOWN, 20);
    checkOutput("gain_sat_min", 128'(o_gain_cur), 128'(16'hFFF4));
    applyStimulus(B_BACK, 1);
    checkOutput("discard_state",    128'(o_state),     128'(3));
    checkOutput("discard_gain_cur", 128'(o_gain_cur),  128'(0));
    checkOutput("discard_no_upd",   128'(o_upd_valid), 128'(0));
    checkOutput("discard_gains",    128'(o_gains),     128'(expGains));

    applyStimulus(B_SEL, 1);
    pressN(B_UP, 2);
    applyStimulus(B_SEL, 1);
    expGains[2*GAIN_W +: GAIN_W] = 16'd2;
    checkOutput("commit2_gains", 128'(o_gains), 128'(expGains));
    checkOutput("commit2_valid", 128'(o_upd_valid), 128'(1));
    applyStimulus(B_BACK, 1);
    checkOutput("band_back_menu", 128'(o_state), 128'(2));
    pressN(B_UP, 3);
    checkOutput("cursor_sat", 128'(o_menu_sel), 128'(2));
    applyStimulus(B_SEL, 1);
    checkOutput("rdsp_state",  128'(o_state),     128'(6));
    checkOutput("rdsp_pulse",  128'(o_dsp_rst),   128'(1));
    checkOutput("rdsp_gains",  128'(o_gains),     128'(0));
    checkOutput("rdsp_valid",  128'(o_upd_valid), 128'(0));
    tick();
    checkOutput("rdsp_exit_state", 128'(o_state),   128'(2));
    checkOutput("rdsp_pulse_end",  128'(o_dsp_rst), 128'(0));

    applyStimulus(B_UP | B_BACK, 1);
    checkOutput("back_wins_state",  128'(o_state),    128'(1));
    checkOutput("back_wins_cursor", 128'(o_menu_sel), 128'(2));
    applyStimulus(B_SEL, 1);
    applyStimulus(B_UP, 1);
    checkOutput("cursor_offset", 128'(o_menu_sel), 128'(1));
    applyStimulus(B_SEL, 1);
    checkOutput("offset_state", 128'(o_state), 128'(5));
    pressN(B_UP, 5);
    checkOutput("offset_sat_max", 128'(o_offset), 128'(3));
    pressN(B_DOWN, 5);
    checkOutput("offset_sat_min", 128'(o_offset), 128'(0));
    applyStimulus(B_BACK, 1);
    checkOutput("offset_back", 128'(o_state), 128'(2));

    applyStimulus(B_DOWN, 1);
    applyStimulus(B_SEL, 1);
    applyStimulus(B_SEL, 1);
    checkOutput("hold_entry_state", 128'(o_state), 128'(4));
    applyStimulus(B_UP, 30);
`ifdef EQ_MENU_AUTOREPEAT_EN
    checkOutput("hold_up_gain", 128'(o_gain_cur), 128'(6));
`else
    checkOutput("hold_up_gain", 128'(o_gain_cur), 128'(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/eq_menu_ctrl.md
# eq_menu_ctrl

Parametrised user-control FSM for the equalizer/visualizer datapath. It converts four debounced button levels into menu navigation, per-band signed gain editing, output-offset selection and a DSP reset. Edited gains are delivered to the DSP through a valid/ready handshake. It sits between the key debouncers and the DSP/I2C-init blocks, clocked on the audio BCLK domain.

## Interface
- N_BAND, 7, number of EQ bands (≥2)
- GAIN_W, 16, signed gain width
- GAIN_MAX, 12, upper gain limit (signed)
- GAIN_MIN, -12, lower gain limit (signed)
- OFFSET_MAX, 3, highest offset code
- REPEAT_DELAY, 400000, cycles before first auto-repeat (macro only)
- REPEAT_RATE, 100000, cycles between repeats (macro only)
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_select / i_back / i_up / i_down  in  1 each  debounced button levels, active-high
- o_i2c_start  out  1  codec init request, level
- i_i2c_done  in  1  codec init finished
- o_state  out  3  current state code
- o_menu_sel  out  2  menu cursor: 0 EQ, 1 OFFSET, 2 RESET
- o_band  out  $clog2(N_BAND)  selected band
- o_gain_cur  out  GAIN_W  working gain of o_band
- o_gains  out  N_BAND*GAIN_W  committed gains, band 0 in LSBs
- o_offset  out  $clog2(OFFSET_MAX+1)  offset code
- o_dsp_rst  out  1  one-cycle DSP reset pulse
- o_upd_valid  out  1  gain update pending
- o_upd_band  out  $clog2(N_BAND)  band of update
- o_upd_gain  out  GAIN_W  gain of update
- i_upd_ready  in  1  DSP accepts update

## Operation
- States/codes: INIT 0, IDLE 1, MENU 2, BAND_SEL 3, SET_GAIN 4, SET_OFFSET 5, RESET_DSP 6.
- Press = rising edge of button level (internal one-cycle edge detect). Same-cycle priority: back > select > up > down; lower ones ignored.
- INIT: o_i2c_start=1; on i_i2c_done -> IDLE, o_i2c_start=0 thereafter.
- IDLE: select -> MENU, o_menu_sel=0.
- MENU: up/down move cursor, saturating 0..2. back -> IDLE. select: EQ -> BAND_SEL (band kept), OFFSET -> SET_OFFSET, RESET -> RESET_DSP.
- BAND_SEL: up/down move band, saturating 0..N_BAND-1. back -> MENU. select -> SET_GAIN only if o_upd_valid=0, else ignored; on entry working gain latched from committed gain.
- SET_GAIN: up/down ±1 on working gain, saturating at GAIN_MAX/GAIN_MIN (signed compare). select: commit working gain into o_gains, raise update, -> BAND_SEL. back: discard working gain, -> BAND_SEL.
- SET_OFFSET: up +1 (saturate OFFSET_MAX), down −1 (saturate 0), select or back -> MENU.
- RESET_DSP: one cycle; all committed gains and offset cleared, o_dsp_rst=1, pending update dropped (o_upd_valid=0), -> MENU.
- Handshake: o_upd_valid held with band/gain stable until cycle where i_upd_ready=1; cleared next edge. Ready without valid ignored.
- o_gain_cur shows working gain in SET_GAIN, committed gain of o_band elsewhere.

## Timing
- All outputs registered. Button edge sampled at edge n -> state/counters updated at edge n (visible after n).
- Commit: o_gains and o_upd_valid change on same edge as SET_GAIN -> BAND_SEL.
- o_dsp_rst high exactly one cycle, coincident with RESET_DSP.
- Reset values: state INIT, o_i2c_start 1, o_menu_sel 0, o_band 0, all gains 0, o_offset 0, o_dsp_rst 0, o_upd_valid 0, o_upd_band 0, o_upd_gain 0.
- Asynchronous reset mid-edit discards working gain and any pending update.

## Configuration
- EQ_MENU_AUTOREPEAT_EN defined: up or down held alone in BAND_SEL, SET_GAIN or SET_OFFSET generates repeat presses after REPEAT_DELAY cycles, then every REPEAT_RATE cycles; counter clears on release, on state change or if other button pressed.
- Undefined: only edges produce presses; REPEAT_* unused, no counters synthesised.

## Structure
- Package eq_menu_pkg: state enum with fixed codes, menu enum, GAIN_W-independent constants.
- Sub-module eq_btn_repeat: per-button edge detect plus optional auto-repeat counter; four instances.

## Test plan
- Reset, i_i2c_done pulse at cycle 5 -> o_state 0 then 1, o_i2c_start falls with it.
- Select, select, up×3, select, up×15, select -> band 3 gain 12 (saturated), o_upd_valid=1 until i_upd_ready, o_upd_band=3, o_upd_gain=12.
- SET_GAIN down×20 from 0 -> −12 (0xFFF4); back -> committed gain stays 0, no update.
- Pending update with ready low, select in BAND_SEL -> stays BAND_SEL; RESET menu select -> o_dsp_rst one cycle, o_gains 0, o_upd_valid 0.
- Up and back same cycle in MENU -> IDLE, cursor unchanged; SET_OFFSET up×5 -> 3, down×5 -> 0.
- With EQ_MENU_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_RATE=4, up held 30 cycles in SET_GAIN -> gain +6 (edge + repeats at 10,14,18,22,26).
